fir_input_pacer: RTL and testbench

//   Upstream feeder for the serial 50-tap FIR filter. Buffers 16-bit samples from the

---
 rtl/fir_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/fir_input_pacer.sv | 143 ++++++++++++++
 tb/tb_fir_input_pacer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the serial 50-tap FIR filter and its input pacer.
// Holds the filter geometry, the pacer defaults and the pacer state encoding.
package fir_pkg;

  localparam int FIR_WIDTH     = 16;
  localparam int FIR_LENGTH    = 50;
  localparam int FIR_OUT_WIDTH = 38;

  localparam int PACER_DEPTH   = 16;
  localparam int PACER_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pacer_state_e;

  // Width that can hold the values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: head is readable combinationally, and level/full/empty update on the edge after push/pop.
// A push is dropped while full and a pop is ignored while empty, so the caller never has to gate them.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_vld_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push       = push_vld_i && !full_o;
  assign pop        = pop_vld_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/fir_input_pacer.sv
// Feeds the serial FIR one sample at a time: IDLE pops, ISSUE pulses for one cycle, WAIT runs until the filter answers or the timer runs out.
// Sample-in to input_valid is 2 cycles; the source is backpressured only when the FIFO is full.
module fir_input_pacer
  import fir_pkg::*;
#(
  parameter int WIDTH   = FIR_WIDTH,
  parameter int DEPTH   = PACER_DEPTH,
  parameter int TIMEOUT = PACER_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       fir_input,
  output logic                   fir_input_valid,
  input  logic                   fir_output_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_timeout,
  output logic                   err_stray
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  pacer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] fir_input_q, fir_input_d;
  logic             fir_input_valid_q, fir_input_valid_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_stray_q, err_stray_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             cnt_expired;

  assign s_ready     = !fifo_full;
  assign push        = s_valid && s_ready;
  assign cnt_expired = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push),
    .push_dat_i (s_data),
    .pop_vld_i  (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fir_output_valid || cnt_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop               = 1'b0;
    fir_input_d       = fir_input_q;
    fir_input_valid_d = 1'b0;
    cnt_d             = cnt_q;
    err_timeout_d     = err_timeout_q;
    err_stray_d       = err_stray_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop               = 1'b1;
          fir_input_d       = fifo_head;
          fir_input_valid_d = 1'b1;
        end
        if (fir_output_valid) begin
          err_stray_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (fir_output_valid) begin
          err_stray_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response landing on the last WAIT cycle still counts as success.
        if (cnt_expired && !fir_output_valid) begin
          err_timeout_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q             <= '0;
      fir_input_q       <= '0;
      fir_input_valid_q <= 1'b0;
      err_timeout_q     <= 1'b0;
      err_stray_q       <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      fir_input_q       <= fir_input_d;
      fir_input_valid_q <= fir_input_valid_d;
      err_timeout_q     <= err_timeout_d;
      err_stray_q       <= err_stray_d;
    end
  end

  assign fir_input       = fir_input_q;
  assign fir_input_valid = fir_input_valid_q;
  assign err_timeout     = err_timeout_q;
  assign err_stray       = err_stray_q;

endmodule

// File: tb/tb_fir_input_pacer.sv
// Bench for fir_input_pacer: directed vector table, hand-written corner sequences and a random run,
// all checked against a timeline model of the pacer built from queues and cycle stamps.
module tb_fir_input_pacer;

  localparam int W   = 16;
  localparam int D   = 16;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] fir_input;
  logic         fir_input_valid;
  logic         fir_output_valid;
  logic [4:0]   level;
  logic         err_timeout;
  logic         err_stray;

  fir_input_pacer #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .fir_input        (fir_input),
    .fir_input_valid  (fir_input_valid),
    .fir_output_valid (fir_output_valid),
    .level            (level),
    .err_timeout      (err_timeout),
    .err_stray        (err_stray)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Timeline model: queue contents plus cycle stamps of the pacer's activity.
  logic [W-1:0] mq[$];
  int           idle_at, issue_cyc, resp_cyc, tmo_at, stray_at;
  logic [W-1:0] last_in;
  int           lat_q[$];
  int           pulse_log[$];
  logic [W-1:0] issued_log[$];
  int           tmo_seen;
  logic [W-1:0] src[$];
  logic [W-1:0] pushed[$];
  bit           saw_full;

  typedef struct {
    logic         sv;
    logic [W-1:0] sd;
    logic         fov;
    int           lvl;
    logic         rdy;
    logic         fiv;
    logic [W-1:0] fin;
    logic         et;
    logic         es;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic sv, logic [W-1:0] sd, logic fov, int lvl, logic rdy,
                              logic fiv, logic [W-1:0] fin, logic et, logic es);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fov = fov; v.lvl = lvl; v.rdy = rdy;
    v.fiv = fiv; v.fin = fin; v.et = et; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    lat_q.delete();
    pulse_log.delete();
    issued_log.delete();
    idle_at   = 0;
    issue_cyc = -1;
    resp_cyc  = -1;
    tmo_at    = -1;
    stray_at  = -1;
    tmo_seen  = -1;
    last_in   = '0;
    cyc       = 0;
  endtask

  task automatic do_reset(input int n);
    rst              = 1'b1;
    s_valid          = 1'b0;
    s_data           = '0;
    fir_output_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  function automatic bit in_wait();
    return (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc < idle_at);
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic stray);
    int L;
    bit acc;
    bit do_stray;
    if (fir_input_valid === 1'b1) begin
      pulse_log.push_back(cyc);
      issued_log.push_back(fir_input);
    end
    if (err_timeout === 1'b1 && tmo_seen < 0) tmo_seen = cyc;

    chk("level", 32'(level), 32'(mq.size()));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < D));
    chk("fir_input_valid", 32'(fir_input_valid), 32'(cyc == issue_cyc));
    chk("fir_input", 32'(fir_input), 32'(last_in));
    chk("err_timeout", 32'(err_timeout), 32'(tmo_at >= 0 && cyc >= tmo_at));
    chk("err_stray", 32'(err_stray), 32'(stray_at >= 0 && cyc >= stray_at));

    do_stray         = stray && !in_wait();
    s_valid          = sv;
    s_data           = sd;
    fir_output_valid = (cyc == resp_cyc) || do_stray;
    if (do_stray && stray_at < 0) stray_at = cyc + 1;

    acc = sv && (mq.size() < D);
    if (cyc >= idle_at && mq.size() > 0) begin
      last_in   = mq.pop_front();
      issue_cyc = cyc + 1;
      if (lat_q.size() > 0) L = lat_q.pop_front();
      else L = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
      if (L > 0) begin
        resp_cyc = issue_cyc + L;
        idle_at  = resp_cyc + 1;
      end else begin
        resp_cyc = -1;
        idle_at  = issue_cyc + TMO + 1;
        if (tmo_at < 0) tmo_at = idle_at;
      end
    end
    if (acc) mq.push_back(sd);

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vt[0]  = mk(1'b1, 16'h1234, 1'b0, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 16'h0000, 1'b0, 1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    vt[2]  = mk(1'b0, 16'h0000, 1'b0, 0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, 16'h00A1, 1'b0, 0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1);
    vt[6]  = mk(1'b1, 16'h00A2, 1'b0, 1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1);
    vt[7]  = mk(1'b0, 16'h0000, 1'b0, 1, 1'b1, 1'b1, 16'h00A1, 1'b0, 1'b1);
    vt[8]  = mk(1'b0, 16'h0000, 1'b1, 1, 1'b1, 1'b0, 16'h00A1, 1'b0, 1'b1);
    vt[9]  = mk(1'b0, 16'h0000, 1'b0, 1, 1'b1, 1'b0, 16'h00A1, 1'b0, 1'b1);
    vt[10] = mk(1'b0, 16'h0000, 1'b0, 0, 1'b1, 1'b1, 16'h00A2, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0, 16'h00A2, 1'b0, 1'b1);
    vt[12] = mk(1'b0, 16'h0000, 1'b0, 0, 1'b1, 1'b0, 16'h00A2, 1'b0, 1'b1);

    rst              = 1'b1;
    s_valid          = 1'b0;
    s_data           = '0;
    fir_output_valid = 1'b0;
    do_reset(3);

    // Directed table: latency, stray in IDLE, simultaneous push and pop.
    for (int i = 0; i < 13; i++) begin
      cyc = i;
      chk("vec_level", 32'(level), 32'(vt[i].lvl));
      chk("vec_s_ready", 32'(s_ready), 32'(vt[i].rdy));
      chk("vec_fir_input_valid", 32'(fir_input_valid), 32'(vt[i].fiv));
      chk("vec_fir_input", 32'(fir_input), 32'(vt[i].fin));
      chk("vec_err_timeout", 32'(err_timeout), 32'(vt[i].et));
      chk("vec_err_stray", 32'(err_stray), 32'(vt[i].es));
      s_valid          = vt[i].sv;
      s_data           = vt[i].sd;
      fir_output_valid = vt[i].fov;
      @(posedge clk);
      #1;
    end

    // Timeout: the first sample is never answered, the second is answered after 10 cycles.
    do_reset(2);
    lat_q.push_back(0);
    lat_q.push_back(10);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 16'hCAFE, 1'b0);
    repeat (100) step(1'b0, '0, 1'b0);
    chk("timeout_pulses", 32'(pulse_log.size()), 32'd2);
    if (pulse_log.size() >= 2) begin
      chk("timeout_delay", 32'(tmo_seen - pulse_log[0]), 32'(TMO + 1));
      chk("timeout_reissue", 32'(pulse_log[1] - pulse_log[0]), 32'(TMO + 2));
      chk("timeout_reissue_data", 32'(issued_log[1]), 32'hCAFE);
    end

    // Stray pulse while IDLE with an empty FIFO.
    step(1'b0, '0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);
    chk("stray_no_issue", 32'(pulse_log.size()), 32'd2);

    // Reset in the middle of WAIT with five samples queued.
    lat_q.push_back(0);
    for (int k = 0; k < 6; k++) step(1'b1, 16'h5000 + 16'(k), 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    chk("pre_reset_level", 32'(level), 32'd5);
    chk("pre_reset_errors", 32'({err_timeout, err_stray}), 32'd3);
    do_reset(3);
    repeat (3) step(1'b0, '0, 1'b0);

    // Burst of 20 into a slow filter: backpressure, then strict issue order.
    do_reset(1);
    lat_q.push_back(40);
    lat_q.push_back(TMO);
    lat_q.push_back(1);
    lat_q.push_back(2);
    for (int k = 0; k < 16; k++) lat_q.push_back(3);
    src.delete();
    pushed.delete();
    for (int k = 0; k < 20; k++) begin
      src.push_back(16'($urandom));
      pushed.push_back(src[k]);
    end
    saw_full = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bit sv_b;
      bit acc_b;
      sv_b  = (src.size() > 0);
      acc_b = sv_b && (s_ready === 1'b1);
      if (s_ready === 1'b0) saw_full = 1'b1;
      step(sv_b, sv_b ? src[0] : '0, 1'b0);
      if (acc_b) void'(src.pop_front());
    end
    chk("burst_saw_full", 32'(saw_full), 32'd1);
    chk("burst_src_drained", 32'(src.size()), 32'd0);
    chk("burst_issues", 32'(issued_log.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (k < issued_log.size()) chk("burst_order", 32'(issued_log[k]), 32'(pushed[k]));
    end

    // Random traffic alternating dense and sparse phases, random latency, random strays.
    do_reset(2);
    for (int k = 0; k < 4000; k++) begin
      int  rate;
      bit  sv_r;
      bit  st_r;
      rate = ((k / 500) % 2 == 0) ? 90 : 20;
      sv_r = ($urandom_range(0, 99) < rate);
      st_r = ($urandom_range(0, 63) == 0);
      step(sv_r, 16'($urandom), st_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
